demux_stream: RTL and testbench
===============================

Name: demux_stream

Overview:
- Streaming one-hot demultiplexer; the inverse of the one-hot AND-OR mux.
- Takes one valid/ready input stream tagged with a one-hot destination select and steers each beat to one of N output channels.
- Each output channel has its own 2-entry buffer, so no combinational path runs from any output ready to the input ready.
- Sits between a shared producer (e.g. a decoded request path) and N independent consumers.

Parameters:
- N, 4, number of output channels (N >= 2).
- W, 32, beat data width in bits (W >= 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- i_valid  input  1  input beat valid.
- i_sel  input  N  one-hot destination select; qualified by i_valid.
- i_data  input  W  input beat data.
- o_ready  output  1  input beat accepted when i_valid & o_ready.
- o_valid  output  N  per-channel output valid.
- o_data  output  N*W  per-channel output data, packed [N-1:0][W-1:0].
- i_ready  input  N  per-channel consumer ready.

Behaviour:
- Reset values: every channel EMPTY; o_valid = 0; o_data = 0; o_ready = 0 while rst_n = 0.
- Reset mid-operation discards all buffered beats; there is no partial drain.
- Per-channel occupancy state machine, states EMPTY, ONE and FULL:
  - push only: EMPTY->ONE, ONE->FULL.
  - pop only: FULL->ONE, ONE->EMPTY.
  - push and pop together: ONE->ONE, FULL->FULL.
  - push at EMPTY is never accompanied by a pop.
- Pop on channel k = o_valid[k] & i_ready[k]. o_valid[k] = (state != EMPTY), and o_data[k] is the head entry.
- Channel k is available when its registered state != FULL. This depends only on registered state; a same-cycle pop does not free a FULL slot for a push.
- o_ready = rst_n & AND over k of (~i_sel[k] | available[k]). It is combinational from i_sel and registered state only.
- A one-hot accepted beat pushes into channel sel. Latency: it is visible at o_valid/o_data on the next cycle.
- Throughput is one beat per cycle per channel while the consumer holds i_ready high.
- FIFO order per channel: the head is the oldest entry; a push into ONE with a same-cycle pop makes the new beat the head.
- i_sel == 0 with i_valid: o_ready = 1 and the beat is consumed and discarded; no channel changes.
- Multi-hot i_sel without the feature: broadcast. o_ready = 1 only when every selected channel is available, then all selected channels push the same data.
- Data holds while a channel is EMPTY. Beat data is not cleared on pop; only o_valid deasserts.

Optional Feature:
- Macro: DEMUX_STREAM_ERR_EN.
- Defined:
  - Adds output port o_err (1 bit, reset 0).
  - Any accepted beat whose i_sel is not exactly one-hot (zero or multi-hot) is consumed with o_ready = 1, discarded, and sets o_err.
  - o_err is sticky until reset.
  - Broadcast is disabled.
- Undefined: no o_err port. Zero-select beats are dropped and multi-hot beats are broadcast, as in Behaviour.

Decomposition:
- Package demux_stream_pkg holds:
  - the occupancy enum (EMPTY, ONE, FULL), 2 bits;
  - a function onehot_check(sel) returning {is_zero, is_multi}.
- Sub-module demux_stream_slot (parameter W): the 2-entry buffer plus state machine. Ports: clk, rst_n, push, push_data, pop, available, valid, data.
- demux_stream instantiates N demux_stream_slot instances and owns the o_ready and error logic.

Test Plan:
- Reset and first beat: reset 3 cycles, then i_valid=1, i_sel=4'b0010, i_data=0xA5A5A5A5, all i_ready=0.
  - Expect o_ready=1 that cycle, o_valid=4'b0010 next cycle, o_data[1]=0xA5A5A5A5; all outputs 0 during reset.
- Backpressure fill: push 0x1, 0x2, 0x3 to channel 0 with i_ready[0]=0.
  - Expect o_ready=1, 1, then 0 on the third beat, held 0.
  - Raise i_ready[0]: pops 0x1 that cycle and o_ready=0 still; next cycle o_ready=1, 0x3 accepted, output order 0x1, 0x2, 0x3.
- Streaming: channel 2 with i_ready[2]=1, 8 back-to-back beats 0..7.
  - Expect o_ready=1 every cycle, o_valid[2] continuous from cycle+1, data 0..7 in order.
- Isolation: channel 3 FULL while beats target channel 1.
  - Expect o_ready=1 for channel-1 beats and o_ready=0 only when i_sel=4'b1000.
- Zero select: i_sel=0, i_valid=1.
  - Expect o_ready=1 and no o_valid change; with DEMUX_STREAM_ERR_EN, o_err=1 next cycle and stays 1.
- Multi-hot select: i_sel=4'b0101, data 0x77, channels 0 and 2 EMPTY.
  - Without the macro: o_valid=4'b0101 with both o_data=0x77.
  - With the macro: beat dropped and o_err=1.

Source files
------------

// File: rtl/demux_stream_pkg.sv
// demux_stream_pkg: shared types and helpers for the one-hot stream demux.
// Holds the per-channel occupancy enum and the select-vector classifier.
package demux_stream_pkg;

    // Widest select vector onehot_check can classify.
    localparam int MAX_N = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    // Returns {is_zero, is_multi} for a zero-extended select vector.
    // sel & (sel - 1) clears the lowest set bit; anything left is multi-hot.
    function automatic logic [1:0] onehot_check(input logic [MAX_N-1:0] sel);
        logic is_zero;
        logic is_multi;
        is_zero  = (sel == '0);
        is_multi = ((sel & (sel - MAX_N'(1))) != '0);
        return {is_zero, is_multi};
    endfunction

endpackage

// File: rtl/demux_stream_if.sv
// demux_stream_if: input stream plus N output channels of the demux.
// Ports: i_valid/i_sel/i_data/o_ready (input side), o_valid/o_data/i_ready (outputs).
interface demux_stream_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic                  i_valid;
    logic [N-1:0]          i_sel;
    logic [W-1:0]          i_data;
    logic                  o_ready;
    logic [N-1:0]          o_valid;
    logic [N-1:0][W-1:0]   o_data;
    logic [N-1:0]          i_ready;

    modport master (
        output i_valid, i_sel, i_data, i_ready,
        input  o_ready, o_valid, o_data
    );

    modport slave (
        input  i_valid, i_sel, i_data, i_ready,
        output o_ready, o_valid, o_data
    );

endinterface

// File: rtl/demux_stream_slot.sv
// demux_stream_slot: one 2-entry output buffer with EMPTY/ONE/FULL occupancy.
// Ports: clk, rst_n, push/push_data in, pop in, available/valid/data out.
module demux_stream_slot
    import demux_stream_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         available,
    output logic         valid,
    output logic [W-1:0] data
);

    occ_e         state_q, state_d;
    logic [W-1:0] hd_q, hd_d;
    logic [W-1:0] tl_q, tl_d;
    logic         do_pop;

    assign valid     = (state_q != EMPTY);
    assign available = (state_q != FULL);
    assign data      = hd_q;
    assign do_pop    = pop & valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            hd_q    <= '0;
            tl_q    <= '0;
        end else begin
            state_q <= state_d;
            hd_q    <= hd_d;
            tl_q    <= tl_d;
        end
    end

    // Head register always presents the oldest beat; a pop from FULL
    // shifts the tail forward. Data is left in place on a pop to EMPTY.
    always_comb begin
        state_d = state_q;
        hd_d    = hd_q;
        tl_d    = tl_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    hd_d    = push_data;
                end
            end
            ONE: begin
                if (push && do_pop) begin
                    hd_d = push_data;
                end else if (push) begin
                    state_d = FULL;
                    tl_d    = push_data;
                end else if (do_pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (do_pop) begin
                    hd_d = tl_q;
                    if (push) begin
                        tl_d = push_data;
                    end else begin
                        state_d = ONE;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

endmodule

// File: rtl/demux_stream.sv
// demux_stream: steers a one-hot tagged valid/ready stream to N buffered channels.
// Ports: clk, rst_n, io (demux_stream_if.slave); o_err when DEMUX_STREAM_ERR_EN.
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic clk,
    input  logic rst_n,
`ifdef DEMUX_STREAM_ERR_EN
    output logic o_err,
`endif
    demux_stream_if.slave io
);

    logic [N-1:0]        avail;
    logic [N-1:0]        valid_v;
    logic [N-1:0]        push_v;
    logic [N-1:0]        pop_v;
    logic [N-1:0][W-1:0] data_v;
    logic                fits;
    logic                accept;

    // Every selected channel must have registered room; a same-cycle
    // pop never frees a FULL slot, keeping ready paths registered.
    assign fits   = &(~io.i_sel | avail);
    assign accept = io.i_valid & io.o_ready;
    assign pop_v  = valid_v & io.i_ready;

`ifdef DEMUX_STREAM_ERR_EN
    logic is_zero;
    logic is_multi;
    logic bad;

    assign {is_zero, is_multi} = onehot_check(MAX_N'(io.i_sel));
    assign bad        = is_zero | is_multi;
    // Malformed selects are always swallowed so they cannot stall the source.
    assign io.o_ready = rst_n & (bad | fits);
    assign push_v     = {N{accept & ~bad}} & io.i_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_err <= 1'b0;
        end else if (accept && bad) begin
            o_err <= 1'b1;
        end
    end
`else
    // Zero select falls through as "fits" and is dropped; multi-hot
    // broadcasts once all selected channels have room.
    assign io.o_ready = rst_n & fits;
    assign push_v     = {N{accept}} & io.i_sel;
`endif

    for (genvar k = 0; k < N; k++) begin : g_slot
        demux_stream_slot #(
            .W (W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push_v[k]),
            .push_data (io.i_data),
            .pop       (pop_v[k]),
            .available (avail[k]),
            .valid     (valid_v[k]),
            .data      (data_v[k])
        );
    end

    assign io.o_valid = valid_v;
    assign io.o_data  = data_v;

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed scoreboard bench for demux_stream (N=4, W=32).
// Driver pushes expected beats per channel; a monitor pops and compares.
module tb_demux_stream;

    logic clk = 1'b0;
    logic rst_n;
`ifdef DEMUX_STREAM_ERR_EN
    logic o_err;
`endif

    int total = 0;
    int bad = 0;

    logic [31:0] exp_q[4][$];

    demux_stream_if #(.N(4), .W(32)) io ();

    demux_stream #(
        .N (4),
        .W (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef DEMUX_STREAM_ERR_EN
        .o_err (o_err),
`endif
        .io    (io)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus; o_ready is checked mid-cycle and any
    // accepted beat is queued as expected output on its channels.
    task automatic cyc(input bit v, input logic [3:0] s, input logic [31:0] d,
                       input logic [3:0] r, input bit er, input string nm);
        bit drop;
        @(posedge clk);
        #1;
        io.i_valid = v;
        io.i_sel   = s;
        io.i_data  = d;
        io.i_ready = r;
        @(negedge clk);
        chk(nm, {31'd0, io.o_ready}, {31'd0, er});
`ifdef DEMUX_STREAM_ERR_EN
        drop = ($countones(s) != 1);
`else
        drop = 1'b0;
`endif
        if (v && io.o_ready === 1'b1 && !drop) begin
            for (int k = 0; k < 4; k++) begin
                if (s[k]) exp_q[k].push_back(d);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (io.o_valid[k] === 1'b1) begin
                if (exp_q[k].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_ch%0d got=%h want=none", k, io.o_data[k]);
                end else begin
                    chk($sformatf("ch%0d_data", k), io.o_data[k], exp_q[k][0]);
                    if (io.i_ready[k]) void'(exp_q[k].pop_front());
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        io.i_valid = 1'b1;
        io.i_sel   = 4'b0010;
        io.i_data  = 32'hDEAD_BEEF;
        io.i_ready = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, io.o_ready}, 32'd0);
        chk("rst_valid", {28'd0, io.o_valid}, 32'd0);
        chk("rst_data1", io.o_data[1], 32'd0);
        chk("rst_data3", io.o_data[3], 32'd0);
`ifdef DEMUX_STREAM_ERR_EN
        chk("rst_err", {31'd0, o_err}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        io.i_valid = 1'b0;

        // first beat
        cyc(1, 4'b0010, 32'hA5A5_A5A5, 4'b0000, 1, "first_rdy");
        cyc(0, 4'b0000, 32'h0, 4'b0000, 1, "idle_rdy");
        chk("first_valid", {28'd0, io.o_valid}, 32'h2);
        chk("first_data", io.o_data[1], 32'hA5A5_A5A5);

        // backpressure fill on channel 0
        cyc(1, 4'b0001, 32'h1, 4'b0000, 1, "bp_rdy1");
        cyc(1, 4'b0001, 32'h2, 4'b0000, 1, "bp_rdy2");
        cyc(1, 4'b0001, 32'h3, 4'b0000, 0, "bp_rdy3");
        cyc(1, 4'b0001, 32'h3, 4'b0000, 0, "bp_hold");
        cyc(1, 4'b0001, 32'h3, 4'b0001, 0, "bp_pop_rdy");
        cyc(1, 4'b0001, 32'h3, 4'b0001, 1, "bp_free_rdy");
        cyc(0, 4'b0000, 32'h0, 4'b0011, 1, "bp_drain");
        cyc(0, 4'b0000, 32'h0, 4'b0011, 1, "bp_drain2");

        // streaming on channel 2
        for (int i = 0; i < 8; i++) begin
            cyc(1, 4'b0100, 32'(i), 4'b0100, 1, "st_rdy");
            if (i > 0) chk("st_cont", {31'd0, io.o_valid[2]}, 32'd1);
        end
        cyc(0, 4'b0000, 32'h0, 4'b0100, 1, "st_tail");
        chk("st_last", {31'd0, io.o_valid[2]}, 32'd1);
        cyc(0, 4'b0000, 32'h0, 4'b0100, 1, "st_idle");
        chk("st_empty", {28'd0, io.o_valid}, 32'd0);

        // isolation: channel 3 full, channel 1 keeps flowing
        cyc(1, 4'b1000, 32'h30, 4'b0000, 1, "iso_f0");
        cyc(1, 4'b1000, 32'h31, 4'b0000, 1, "iso_f1");
        cyc(1, 4'b0010, 32'h10, 4'b0010, 1, "iso_c1a");
        cyc(1, 4'b1000, 32'h32, 4'b0010, 0, "iso_c3");
        cyc(1, 4'b0010, 32'h11, 4'b0010, 1, "iso_c1b");
        repeat (3) cyc(0, 4'b0000, 32'h0, 4'b1010, 1, "iso_drain");

        // zero select
        cyc(1, 4'b0000, 32'h55, 4'b1111, 1, "zero_rdy");
        cyc(0, 4'b0000, 32'h0, 4'b0000, 1, "zero_idle");
        chk("zero_valid", {28'd0, io.o_valid}, 32'd0);
`ifdef DEMUX_STREAM_ERR_EN
        chk("zero_err", {31'd0, o_err}, 32'd1);
        cyc(0, 4'b0000, 32'h0, 4'b0000, 1, "zero_idle2");
        chk("zero_err_stk", {31'd0, o_err}, 32'd1);
`endif

        // multi-hot select
        cyc(1, 4'b0101, 32'h77, 4'b0000, 1, "mh_rdy");
        cyc(0, 4'b0000, 32'h0, 4'b0000, 1, "mh_idle");
`ifdef DEMUX_STREAM_ERR_EN
        chk("mh_valid", {28'd0, io.o_valid}, 32'd0);
        chk("mh_err", {31'd0, o_err}, 32'd1);
`else
        chk("mh_valid", {28'd0, io.o_valid}, 32'h5);
        chk("mh_data0", io.o_data[0], 32'h77);
        chk("mh_data2", io.o_data[2], 32'h77);
`endif
        repeat (3) cyc(0, 4'b0000, 32'h0, 4'b1111, 1, "end_drain");

        for (int k = 0; k < 4; k++) begin
            chk($sformatf("left_ch%0d", k), 32'(exp_q[k].size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
